axis_pkt_gen: RTL

- Synthesizable, runtime-configurable AXI-Stream packet generator. Successor to the fixed-length, single-flow UDP test generator.
- Emits Ethernet/IPv4/UDP packets. Each packet is one header beat followed by sequence-numbered payload beats.
- Supports multiple flows in round-robin order, programmable packet length, packet count and inter-packet gap.
- Feeds the panic RX input for throughput and ordering tests. Keeps packet and byte statistics.

---
 rtl/axis_pkt_gen_pkg.sv | 33 +++
 rtl/axis_pkt_gen_if.sv | 14 +
 rtl/axis_pkt_gen_lfsr.sv | 19 +
 rtl/axis_pkt_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_gen_pkg.sv
// rtl/axis_pkt_gen_pkg.sv - shared types, header offsets and constants for the packet generator
package pktgen_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam int LEN_HI_OFF  = 16;
    localparam int LEN_LO_OFF  = 17;
    localparam int FLOW_OFF    = 35;
    localparam int ETH_HDR_LEN = 14;

    localparam logic [15:0] LFSR_SEED      = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam logic [6:0]  THROTTLE_LIMIT = 7'd100;

    // Byte k of the beat sits at bits [8k+7:8k]; bytes 16/17 (IP length) and 35 (flow) are patched per packet.
    localparam logic [511:0] HDR_TEMPLATE_DEFAULT =
        512'h1514_00000000_00000000_00000000_00000000_00000000_00000000_B7120000_0200000A_0100000A_00001140_00400000_00000045_00085554_5352515A_D5D4D3D2_D1DA;

    function automatic logic [15:0] clamp_beats(input logic [15:0] b, input logic [15:0] max_b);
        if (b == 16'd0)
            return 16'd1;
        else if (b > max_b)
            return max_b;
        else
            return b;
    endfunction

endpackage

// File: rtl/axis_pkt_gen_if.sv
// rtl/axis_pkt_gen_if.sv - AXI-Stream style master/slave bundle for the packet generator output
interface axis_pkt_gen_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_gen_lfsr.sv
// rtl/axis_pkt_gen_lfsr.sv - free-running Galois LFSR that gates beat offers to ~78% load
module pktgen_lfsr
    import pktgen_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic allow
);
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr_q <= LFSR_SEED;
        else
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    assign allow = (lfsr_q[6:0] < THROTTLE_LIMIT);
endmodule

// File: rtl/axis_pkt_gen.sv
// rtl/axis_pkt_gen.sv - multi-flow Ethernet/IPv4/UDP AXIS packet generator; PKTGEN_THROTTLE_EN adds LFSR throttling
module axis_pkt_gen
    import pktgen_pkg::*;
#(
    parameter int             AXIS_DATA_WIDTH = 512,
    parameter int             AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int             FLOW_ID_WIDTH   = 5,
    parameter int             MAX_BEATS       = 32,
    parameter logic [511:0]   HEADER_TEMPLATE = HDR_TEMPLATE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    input  logic                     cfg_stop,
    input  logic [15:0]              cfg_pkt_beats,
    input  logic [31:0]              cfg_pkt_count,
    input  logic [7:0]               cfg_gap,
    input  logic [FLOW_ID_WIDTH-1:0] cfg_flow_max,
    axis_pkt_gen_if.master           m_axis,
    output logic                     busy,
    output logic [31:0]              stat_pkt_count,
    output logic [63:0]              stat_byte_count
);
    localparam logic [15:0] KEEP16 = 16'(AXIS_KEEP_WIDTH);
    localparam logic [15:0] HLEN16 = 16'(ETH_HDR_LEN);

    state_t                     state_q, state_n;
    logic [15:0]                beats_q, beats_n, idx_q, idx_n, len_v;
    logic [31:0]                count_q, count_n, seq_q, seq_n, pkt_q, pkt_n;
    logic [7:0]                 gap_q, gap_n, gap_cnt_q, gap_cnt_n;
    logic [FLOW_ID_WIDTH-1:0]   flow_max_q, flow_max_n, flow_q, flow_n;
    logic                       stop_q, stop_n, tvalid_q, tvalid_n, tlast_q, tlast_n;
    logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_n, hdr, pay;
    logic [63:0]                byte_q, byte_n;
    logic                       hs, present, allow;

`ifdef PKTGEN_THROTTLE_EN
    pktgen_lfsr u_lfsr (.clk(clk), .rst(rst), .allow(allow));
`else
    assign allow = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beats_q    <= 16'd1;
            count_q    <= '0;
            gap_q      <= '0;
            flow_max_q <= '0;
            seq_q      <= 32'd1;
            flow_q     <= '0;
            idx_q      <= '0;
            gap_cnt_q  <= '0;
            stop_q     <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            pkt_q      <= '0;
            byte_q     <= '0;
        end else begin
            state_q    <= state_n;
            beats_q    <= beats_n;
            count_q    <= count_n;
            gap_q      <= gap_n;
            flow_max_q <= flow_max_n;
            seq_q      <= seq_n;
            flow_q     <= flow_n;
            idx_q      <= idx_n;
            gap_cnt_q  <= gap_cnt_n;
            stop_q     <= stop_n;
            tvalid_q   <= tvalid_n;
            tlast_q    <= tlast_n;
            tdata_q    <= tdata_n;
            pkt_q      <= pkt_n;
            byte_q     <= byte_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        beats_n    = beats_q;
        count_n    = count_q;
        gap_n      = gap_q;
        flow_max_n = flow_max_q;
        seq_n      = seq_q;
        flow_n     = flow_q;
        idx_n      = idx_q;
        gap_cnt_n  = gap_cnt_q;
        stop_n     = stop_q || cfg_stop;
        tvalid_n   = tvalid_q;
        tlast_n    = tlast_q;
        tdata_n    = tdata_q;
        pkt_n      = pkt_q;
        byte_n     = byte_q;
        present    = 1'b0;
        hs         = tvalid_q && m_axis.tready;

        if (hs)
            byte_n = byte_q + 64'(AXIS_KEEP_WIDTH);

        // idx_n always names the beat to be offered next; present asks for it to be loaded.
        case (state_q)
            IDLE: begin
                if (cfg_start && !cfg_stop) begin
                    beats_n    = clamp_beats(cfg_pkt_beats, 16'(MAX_BEATS));
                    count_n    = cfg_pkt_count;
                    gap_n      = cfg_gap;
                    flow_max_n = cfg_flow_max;
                    pkt_n      = '0;
                    byte_n     = '0;
                    idx_n      = '0;
                    state_n    = HDR;
                    present    = 1'b1;
                end
            end
            HDR, PAYLOAD: begin
                if (hs) begin
                    tvalid_n = 1'b0;
                    tlast_n  = 1'b0;
                    if (tlast_q) begin
                        seq_n  = seq_q + 32'd1;
                        flow_n = (flow_q == flow_max_q) ? '0 : flow_q + FLOW_ID_WIDTH'(1);
                        pkt_n  = pkt_q + 32'd1;
                        idx_n  = '0;
                        if (stop_q || cfg_stop || (count_q != '0 && pkt_n == count_q)) begin
                            state_n = IDLE;
                        end else if (gap_q != '0) begin
                            state_n   = GAP;
                            gap_cnt_n = gap_q;
                        end else begin
                            state_n = HDR;
                            present = 1'b1;
                        end
                    end else begin
                        idx_n   = idx_q + 16'd1;
                        state_n = PAYLOAD;
                        present = 1'b1;
                    end
                end else if (!tvalid_q) begin
                    present = 1'b1;
                end
            end
            GAP: begin
                if (stop_q || cfg_stop) begin
                    state_n = IDLE;
                end else if (gap_cnt_q <= 8'd1) begin
                    state_n = HDR;
                    present = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt_q - 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n == IDLE)
            stop_n = 1'b0;

        len_v = beats_n * KEEP16 - HLEN16;
        hdr = '0;
        hdr[511:0] = HEADER_TEMPLATE;
        hdr[LEN_HI_OFF*8 +: 8] = len_v[15:8];
        hdr[LEN_LO_OFF*8 +: 8] = len_v[7:0];
        hdr[FLOW_OFF*8 +: 8]   = 8'(flow_n);
        pay = '0;
        pay[31:0] = seq_n + 32'(idx_n);

        if (present && allow) begin
            tvalid_n = 1'b1;
            tlast_n  = (idx_n == beats_n - 16'd1);
            tdata_n  = (idx_n == 16'd0) ? hdr : pay;
        end else if (present) begin
            tvalid_n = 1'b0;
        end
    end

    assign m_axis.tdata   = tdata_q;
    assign m_axis.tkeep   = '1;
    assign m_axis.tvalid  = tvalid_q;
    assign m_axis.tlast   = tlast_q;
    assign busy           = (state_q != IDLE);
    assign stat_pkt_count  = pkt_q;
    assign stat_byte_count = byte_q;
endmodule
